// File: rtl/lab1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab1_pkg
//  Description : Shared types and constants for the LAB1 operand loader.
//                Contains the operand, rule and result typedefs, the operand
//                count, and the loader FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package lab1_pkg;

    localparam int LAB1_NUM_OPS = 6;

    typedef logic        [3:0] operand_t;
    typedef logic        [2:0] rule_t;
    typedef logic signed [9:0] result_t;

    // Loader FSM encoding. Plain vector constants keep the encoding visible
    // to older tools and to waveform viewers without enum support.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t EVAL = 2'd2;
    localparam state_t HOLD = 2'd3;

endpackage
`default_nettype wire

// File: rtl/lab1_operand_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : lab1_operand_loader_if
//  Description : Stream interface of the LAB1 operand loader.
//                Carries the serial operand input handshake
//                (in_valid/in_ready/in_data/in_rule) and the result output
//                handshake (res_valid/res_ready/res_data).
//                master : operand source / result consumer side
//                slave  : the loader itself
//  Revision    : 1.0  initial release
// ============================================================================
interface lab1_operand_loader_if #(
    parameter int DATA_W = 4,
    parameter int RULE_W = 3,
    parameter int RES_W  = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic [RULE_W-1:0]       in_rule;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [RES_W-1:0] res_data;

    modport master (
        output in_valid, in_data, in_rule, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_data, in_rule, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface
`default_nettype wire

// File: rtl/lab1_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : lab1_operand_loader
//  Description : Upstream stage for the LAB1 evaluator. Assembles six serial
//                4-bit operands plus a rule (taken from the first beat) into
//                registered outputs feeding LAB1, captures LAB1's signed
//                result one cycle after the last beat, and returns it over a
//                valid/ready handshake.
//  Ports       : clk, rst_n (async active-low)
//                bus        - lab1_operand_loader_if.slave (in_*/res_*)
//                op_0..op_5 - registered operands to LAB1 in_0..in_5
//                op_rule    - registered rule to LAB1 in_rule
//                lab_out    - LAB1 combinational result
//                err_timeout- one-cycle pulse on mid-frame abort
//  Options     : LAB1_FE_TIMEOUT_EN enables the mid-frame idle timeout;
//                without it err_timeout is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module lab1_operand_loader
    import lab1_pkg::*;
#(
    parameter int NUM_OPS = LAB1_NUM_OPS,
    parameter int DATA_W  = 4,
    parameter int RULE_W  = 3,
    parameter int RES_W   = 10,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lab1_operand_loader_if.slave    bus,
    output logic [DATA_W-1:0]       op_0,
    output logic [DATA_W-1:0]       op_1,
    output logic [DATA_W-1:0]       op_2,
    output logic [DATA_W-1:0]       op_3,
    output logic [DATA_W-1:0]       op_4,
    output logic [DATA_W-1:0]       op_5,
    output logic [RULE_W-1:0]       op_rule,
    input  logic signed [RES_W-1:0] lab_out,
    output logic                    err_timeout
);

    localparam int CNT_W = $clog2(NUM_OPS);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_W-1:0]       ops_q [NUM_OPS];
    logic [DATA_W-1:0]       ops_d [NUM_OPS];
    logic [RULE_W-1:0]       rule_q, rule_d;
    logic signed [RES_W-1:0] res_q, res_d;
    logic                    res_valid_q, res_valid_d;
    logic                    w_in_ready;
    logic                    w_accept;

`ifdef LAB1_FE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign w_in_ready = (state_q == IDLE) || (state_q == LOAD);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ops_d       = ops_q;
        rule_d      = rule_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
`ifdef LAB1_FE_TIMEOUT_EN
        idle_d      = '0;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    ops_d[0] = bus.in_data;
                    rule_d   = bus.in_rule;
                    count_d  = CNT_W'(1);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (w_accept) begin
                    ops_d[count_q] = bus.in_data;
                    if (count_q == CNT_W'(NUM_OPS - 1)) begin
                        state_d = EVAL;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
`ifdef LAB1_FE_TIMEOUT_EN
                else begin
                    // The cycle that would make the idle count reach TIMEOUT
                    // aborts the frame; operands are left as they are.
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`endif
            end
            EVAL: begin
                // Operands have been stable for a full cycle, so LAB1's
                // combinational output has settled by this edge.
                res_d       = lab_out;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    count_d     = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            for (int i = 0; i < NUM_OPS; i++) begin
                ops_q[i] <= '0;
            end
            rule_q      <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
`ifdef LAB1_FE_TIMEOUT_EN
            idle_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ops_q       <= ops_d;
            rule_q      <= rule_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
`ifdef LAB1_FE_TIMEOUT_EN
            idle_q      <= idle_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_q;

    assign op_0    = ops_q[0];
    assign op_1    = ops_q[1];
    assign op_2    = ops_q[2];
    assign op_3    = ops_q[3];
    assign op_4    = ops_q[4];
    assign op_5    = ops_q[5];
    assign op_rule = rule_q;

`ifdef LAB1_FE_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lab1_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lab1_operand_loader
//  Description : Self-checking bench for lab1_operand_loader. A frame-level
//                model predicts outputs every cycle; directed frames with
//                hand-computed literals pin the model. LAB1 is stubbed by
//                driving lab_out with a per-frame constant.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lab1_operand_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lab1_operand_loader_if #(.DATA_W(4), .RULE_W(3), .RES_W(10)) bus ();

    logic [3:0]        op_0, op_1, op_2, op_3, op_4, op_5;
    logic [2:0]        op_rule;
    logic signed [9:0] lab_out;
    logic              err_timeout;
    logic [3:0]        ops_act [6];

    lab1_operand_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .op_0        (op_0),
        .op_1        (op_1),
        .op_2        (op_2),
        .op_3        (op_3),
        .op_4        (op_4),
        .op_5        (op_5),
        .op_rule     (op_rule),
        .lab_out     (lab_out),
        .err_timeout (err_timeout)
    );

    always_comb begin
        ops_act[0] = op_0; ops_act[1] = op_1; ops_act[2] = op_2;
        ops_act[3] = op_3; ops_act[4] = op_4; ops_act[5] = op_5;
    end

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [3:0]        m_ops [6];
    logic [2:0]        m_rule;
    logic signed [9:0] m_res;
    int                m_n;      // beats collected in the current frame
    bit                m_eval;   // full frame collected, result due next edge
    bit                m_rv;     // result pending for the consumer
    bit                m_err;
    int                m_idle;
    logic              m_in_ready;

    assign m_in_ready = !m_eval && !m_rv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) m_ops[i] <= '0;
            m_rule <= '0; m_res <= '0; m_n <= 0; m_eval <= 1'b0;
            m_rv <= 1'b0; m_err <= 1'b0; m_idle <= 0;
        end else begin
            m_err <= 1'b0;
            if (m_rv) begin
                if (bus.res_ready) m_rv <= 1'b0;
            end else if (m_eval) begin
                m_res  <= lab_out;
                m_rv   <= 1'b1;
                m_eval <= 1'b0;
            end else if (bus.in_valid) begin
                m_ops[m_n] <= bus.in_data;
                if (m_n == 0) m_rule <= bus.in_rule;
                m_idle <= 0;
                if (m_n == 5) begin
                    m_n    <= 0;
                    m_eval <= 1'b1;
                end else begin
                    m_n <= m_n + 1;
                end
            end
`ifdef LAB1_FE_TIMEOUT_EN
            else if (m_n != 0) begin
                if (m_idle == 15) begin
                    m_err  <= 1'b1;
                    m_n    <= 0;
                    m_idle <= 0;
                end else begin
                    m_idle <= m_idle + 1;
                end
            end
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("in_ready", bus.in_ready, m_in_ready);
            chk("res_valid", bus.res_valid, m_rv);
            if (m_rv) chk("res_data", bus.res_data, m_res);
            for (int i = 0; i < 6; i++) chk("op", ops_act[i], m_ops[i]);
            chk("op_rule", op_rule, m_rule);
            chk("err_timeout", err_timeout, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [3:0] d, input logic [2:0] r);
        bit acc;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_rule  = r;
        do begin
            acc = bus.in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL beat_accept: got not-accepted expected accepted");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic frame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] d3, input logic [3:0] d4, input logic [3:0] d5,
                         input logic [2:0] r0, input logic [2:0] rn);
        beat(d0, r0); beat(d1, rn); beat(d2, rn);
        beat(d3, rn); beat(d4, rn); beat(d5, rn);
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        bus.res_ready = 1'b1;
        while (!bus.res_valid && n < 20) begin
            step();
            n++;
        end
        if (!bus.res_valid) begin
            checks++; errors++;
            $display("FAIL res_wait: got res_valid=0 expected res_valid=1");
        end
        step();
        bus.res_ready = 1'b0;
    endtask

    task automatic chk_ops(input string name, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3,
                           input logic [3:0] d4, input logic [3:0] d5);
        chk({name, "_op0"}, op_0, d0); chk({name, "_op1"}, op_1, d1);
        chk({name, "_op2"}, op_2, d2); chk({name, "_op3"}, op_3, d3);
        chk({name, "_op4"}, op_4, d4); chk({name, "_op5"}, op_5, d5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_rule = '0;
        bus.res_ready = 1'b0; lab_out = '0;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk_ops("rst", 0, 0, 0, 0, 0, 0);
        chk("rst_rule", op_rule, 0);
        chk("rst_err", err_timeout, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Frame 1: 1..6, rule 5, result -37; latency pinned.
        lab_out = -10'sd37;
        frame(1, 2, 3, 4, 5, 6, 3'd5, 3'd5);
        chk("lat_eval_rv", bus.res_valid, 0);
        step();
        chk("lat_hold_rv", bus.res_valid, 1);
        chk_ops("f1", 1, 2, 3, 4, 5, 6);
        chk("f1_rule", op_rule, 5);
        chk("f1_res", bus.res_data, -37);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("f1_idle_ready", bus.in_ready, 1);
        chk("f1_idle_rv", bus.res_valid, 0);

        // Frame 2: three-cycle gap between beats 2 and 3.
        beat(1, 3'd5); beat(2, 3'd5);
        repeat (3) step();
        beat(3, 3'd5); beat(4, 3'd5); beat(5, 3'd5); beat(6, 3'd5);
        wait_res();
        chk_ops("f2", 1, 2, 3, 4, 5, 6);
        chk("f2_res_model", m_res, -37);

        // Frame 3: consumer stalls 5 cycles while beats are offered.
        lab_out = 10'sd511;
        frame(10, 11, 12, 13, 14, 15, 3'd1, 3'd1);
        step();
        bus.in_valid = 1'b1; bus.in_data = 4'd0; bus.in_rule = 3'd6;
        repeat (5) begin
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_res", bus.res_data, 511);
            step();
        end
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("f3_idle_ready", bus.in_ready, 1);
        chk_ops("f3", 10, 11, 12, 13, 14, 15);
        chk("f3_rule", op_rule, 1);

        // Frame 4: rule taken from the first beat only; most negative result.
        lab_out = -10'sd512;
        frame(3, 1, 4, 1, 5, 9, 3'd7, 3'd2);
        wait_res();
        chk("f4_rule", op_rule, 7);
        chk("f4_res", m_res, -512);

        // Reset mid-frame, then a clean frame of nines.
        lab_out = 10'sd0;
        beat(2, 3'd3); beat(2, 3'd3); beat(2, 3'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_op0", op_0, 0);
        chk("arst_rule", op_rule, 0);
        chk("arst_res", bus.res_data, 0);
        chk("arst_rv", bus.res_valid, 0);
        chk("arst_ready", bus.in_ready, 1);
        #10 rst_n = 1'b1;
        step();
        lab_out = 10'sd100;
        frame(9, 9, 9, 9, 9, 9, 3'd4, 3'd4);
        wait_res();
        chk_ops("f5", 9, 9, 9, 9, 9, 9);
        chk("f5_rule", op_rule, 4);

`ifdef LAB1_FE_TIMEOUT_EN
        begin
            int fired;
            fired = 0;
            beat(1, 3'd6); beat(2, 3'd6); beat(3, 3'd6); beat(4, 3'd6);
            for (int i = 1; i <= 20; i++) begin
                step();
                if (err_timeout && fired == 0) fired = i;
            end
            chk("to_cycle", fired, 16);
            chk("to_rv", bus.res_valid, 0);
            chk("to_ready", bus.in_ready, 1);
            lab_out = -10'sd5;
            frame(6, 5, 4, 3, 2, 1, 3'd0, 3'd0);
            wait_res();
            chk_ops("f6", 6, 5, 4, 3, 2, 1);
        end
`endif

        repeat (3) step();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab1_operand_loader.md
Name: lab1_operand_loader

Overview:
Upstream stage for the LAB1 evaluator. It accepts a serial stream of 4-bit operands over a valid/ready handshake and assembles six operands plus a 3-bit rule. It holds them stable on registered outputs wired to LAB1, captures LAB1's signed 10-bit result, and returns that result over a valid/ready output handshake. Sits between the operand source (bus or testbench driver) and the combinational LAB1 block.

Parameters:
NUM_OPS, 6, operands per frame (LAB1 has in_0..in_5)
DATA_W, 4, operand width
RULE_W, 3, rule width
RES_W, 10, signed result width
TIMEOUT, 16, idle cycles allowed mid-frame (used only with LAB1_FE_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  serial beat valid
in_ready  output  1  loader can accept a beat
in_data  input  DATA_W  operand nibble
in_rule  input  RULE_W  rule; sampled only on the first beat of a frame
op_0..op_5  output  DATA_W each  registered operands to LAB1 in_0..in_5
op_rule  output  RULE_W  registered rule to LAB1 in_rule
lab_out  input  RES_W signed  LAB1 out
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  RES_W signed  captured result
err_timeout  output  1  one-cycle pulse on frame abort; constant 0 without LAB1_FE_TIMEOUT_EN

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat count=0, all op_*, op_rule, res_data=0, res_valid=0, err_timeout=0. in_ready is 1 out of reset.
- FSM states: IDLE, LOAD, EVAL, HOLD.
- IDLE: in_ready=1. On an accepted beat (in_valid & in_ready), capture in_data into op_0 and in_rule into op_rule. Set count=1 and go to LOAD.
- LOAD: in_ready=1. Each accepted beat writes op_[count], then count increments. in_rule is ignored. A cycle with in_valid=0 stalls with count and ops unchanged. The beat that writes op_5 moves the FSM to EVAL.
- EVAL (exactly 1 cycle): in_ready=0. Ops are stable, so LAB1 settles combinationally. At the end of the cycle, latch lab_out into res_data, set res_valid=1, go to HOLD.
- HOLD: in_ready=0; res_valid=1; res_data is stable. On res_valid & res_ready: res_valid=0, count=0, go to IDLE. op_* keep their last values until overwritten.
- Latency: the last beat is accepted at cycle N, EVAL runs at N+1, res_valid is high from N+2. Best-case frame-to-frame throughput is 8 cycles, reached when res_ready is held high.
- Beats offered while in_ready=0 are not consumed. The source must hold them.
- res_data is sign-preserving. No arithmetic is done in this block.
- Reset asserted mid-frame or mid-HOLD discards everything immediately. No result is emitted.

Optional Feature:
Macro LAB1_FE_TIMEOUT_EN.
- Defined: in LOAD, an idle counter increments on every cycle with in_valid=0 and clears on any accepted beat. When it reaches TIMEOUT, the block pulses err_timeout for 1 cycle, clears count, returns to IDLE, and leaves res_valid at 0. The partial frame is dropped; op_* are not cleared.
- Undefined: no counter; LOAD stalls indefinitely; err_timeout is tied to 0.

Decomposition:
- Shared package lab1_pkg holds:
  - typedef state_t {IDLE, LOAD, EVAL, HOLD}
  - typedefs operand_t (logic [3:0]), rule_t (logic [2:0]), result_t (logic signed [9:0])
  - localparam LAB1_NUM_OPS=6
- No sub-module; the FSM and operand register file stay flat in one module.
- TESTBED instantiates the loader ahead of LAB1 in a new bench.

Test Plan:
- Reset then six beats 1,2,3,4,5,6 with rule=3'd5, LAB1 stubbed so lab_out=-10'sd37 -> op_0..op_5=1..6, op_rule=5, res_valid rises 2 cycles after beat 6, res_data=-37.
- in_valid gaps of 3 cycles between beats 2 and 3 -> count holds, final ops 1..6 unchanged, result as above.
- res_ready held low 5 cycles in HOLD, new beats offered -> in_ready=0, res_data stable, beats not consumed; res_ready=1 -> IDLE next cycle.
- Rule changed to 3'd2 on beats 2..6, first beat rule=3'd7 -> op_rule=7.
- rst_n pulsed low after 3 beats -> all outputs 0 asynchronously; next frame 9,9,9,9,9,9 loads cleanly.
- LAB1_FE_TIMEOUT_EN, TIMEOUT=16: stop after 4 beats -> err_timeout pulses at idle cycle 16, state IDLE, res_valid stays 0; next full frame succeeds.
